// File: rtl/serdesphy_mdec_pkg.sv
// Shared definitions for the Manchester stream decoder.
//   SYM_HI_LO / SYM_LO_HI : the two legal Manchester symbols
//   POL_NORMAL / POL_INVERT: symbol polarity selection
//   decode_symbol(sym, pol): returns {err, bit} for one 2-bit symbol
package serdesphy_mdec_pkg;

    localparam logic [1:0] SYM_HI_LO  = 2'b10;
    localparam logic [1:0] SYM_LO_HI  = 2'b01;
    localparam logic       POL_NORMAL = 1'b0;
    localparam logic       POL_INVERT = 1'b1;

    // Invalid symbols (00/11) decode to bit 0 with the error flag set.
    function automatic logic [1:0] decode_symbol(input logic [1:0] sym, input logic pol);
        logic [1:0] res;
        res = 2'b10;
        if (sym == SYM_LO_HI) begin
            res = {1'b0, pol == POL_NORMAL};
        end else if (sym == SYM_HI_LO) begin
            res = {1'b0, pol == POL_INVERT};
        end
        return res;
    endfunction

endpackage

// File: rtl/serdesphy_sync_fifo.sv
// Synchronous FIFO with registered occupancy and wrapping pointers.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data (ignored when full)
//   pop, dout     : read request (ignored when empty) and head word
//   full, empty   : occupancy flags
//   count         : occupancy, $clog2(DEPTH)+1 bits
// dout reads the head entry combinationally and is forced to zero when empty,
// so nothing left in storage is visible after a reset.
module serdesphy_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    import serdesphy_mdec_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serdesphy_manchester_stream_decoder.sv
// Streaming Manchester decoder: 2*DATA_W symbol bits in, DATA_W decoded bits
// plus a per-bit invalid-symbol mask out, buffered in a DEPTH-word FIFO.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready    : symbol word handshake (ready = FIFO not full)
//   polarity                     : 0 -> 10=0,01=1 ; 1 -> inverted
//   out_data/out_err_mask/out_error/out_valid/out_ready : FIFO head handshake
//   err_count, err_clr           : saturating erroring-word counter and its
//                                  clear; present only when
//                                  SERDESPHY_MDEC_ERRCNT_EN is defined
module serdesphy_manchester_stream_decoder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DATA_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                polarity,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W-1:0]   out_err_mask,
    output logic                out_error,
    output logic                out_valid,
    input  logic                out_ready
`ifdef SERDESPHY_MDEC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]    err_count,
    input  logic                err_clr
`endif
);
    import serdesphy_mdec_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [DATA_W-1:0]   dec_data;
    logic [DATA_W-1:0]   dec_mask;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [2*DATA_W-1:0] fifo_dout;

    always_comb begin
        dec_data = '0;
        dec_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            {dec_mask[i], dec_data[i]} = decode_symbol(in_data[2*i +: 2], polarity);
        end
    end

    // No bypass: a full FIFO refuses input even if the head pops this cycle.
    assign in_ready = (fifo_count < DEPTH_CNT);
    assign accept   = in_valid && in_ready;

    serdesphy_sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({dec_mask, dec_data}),
        .pop   (out_valid && out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid                = !fifo_empty;
    assign {out_err_mask, out_data} = fifo_dout;
    assign out_error                = |out_err_mask;

    full_matches_count: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == DEPTH_CNT));

`ifdef SERDESPHY_MDEC_ERRCNT_EN
    logic accept_err;
    assign accept_err = accept && (|dec_mask);

    // A clear coinciding with an erroring accept leaves that word counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= accept_err ? CNT_W'(1) : '0;
        end else if (accept_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_serdesphy_manchester_stream_decoder.sv
// Self-checking bench for serdesphy_manchester_stream_decoder (DATA_W=8,
// DEPTH=4, CNT_W=2). Error-counter checks are built when
// SERDESPHY_MDEC_ERRCNT_EN is defined.
module tb_serdesphy_manchester_stream_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        polarity;
    logic [7:0]  out_data;
    logic [7:0]  out_err_mask;
    logic        out_error;
    logic        out_valid;
    logic        out_ready;
`ifdef SERDESPHY_MDEC_ERRCNT_EN
    logic [1:0]  err_count;
    logic        err_clr;
`endif

    int unsigned checks = 0;
    int unsigned fails  = 0;
    logic [15:0] q[$];      // expected {mask, data} in FIFO order
    int unsigned em = 0;    // expected err_count
    bit          acc;

    serdesphy_manchester_stream_decoder #(
        .DATA_W (8),
        .DEPTH  (4),
        .CNT_W  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .polarity     (polarity),
        .out_data     (out_data),
        .out_err_mask (out_err_mask),
        .out_error    (out_error),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        ,
        .err_count    (err_count),
        .err_clr      (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    // Manchester rule: 01 means 1 and 10 means 0 under normal polarity,
    // swapped when inverted; anything else is an error that reads as 0.
    function automatic logic [15:0] ref_decode(input logic [15:0] w, input logic pol);
        logic [7:0] d;
        logic [7:0] m;
        logic [1:0] s;
        d = '0;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            s = w[2*i +: 2];
            if (s == 2'b01)      d[i] = ~pol;
            else if (s == 2'b10) d[i] = pol;
            else                 m[i] = 1'b1;
        end
        return {m, d};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(7) == 0) w[2*i +: 2] = ($urandom_range(1) != 0) ? 2'b11 : 2'b00;
            else                        w[2*i +: 2] = ($urandom_range(1) != 0) ? 2'b01 : 2'b10;
        end
        return w;
    endfunction

    // One clock: compare outputs to the model, then advance the model
    // across the rising edge. Entered and left at the falling edge.
    task automatic step(output bit accepted);
        logic [15:0] head;
        logic [15:0] nw;
        bit          popped;
        #1;
        check("in_ready", in_ready, q.size() < 4);
        check("out_valid", out_valid, q.size() != 0);
        head = (q.size() != 0) ? q[0] : 16'h0;
        check("out_data", out_data, head[7:0]);
        check("out_err_mask", out_err_mask, head[15:8]);
        check("out_error", out_error, |head[15:8]);
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        check("err_count", err_count, em);
`endif
        accepted = in_valid && (q.size() < 4);
        popped   = (q.size() != 0) && out_ready;
        nw       = ref_decode(in_data, polarity);
        @(posedge clk);
        if (popped)   void'(q.pop_front());
        if (accepted) q.push_back(nw);
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        if (err_clr)                          em = (accepted && nw[15:8] != 0) ? 1 : 0;
        else if (accepted && nw[15:8] != 0 && em != 3) em++;
`endif
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w, input logic pol);
        bit a;
        in_data  = w;
        polarity = pol;
        in_valid = 1'b1;
        step(a);
        in_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [7:0] d, input logic [7:0] m);
        #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_mask"}, out_err_mask, m);
        check({tag, "_error"}, out_error, m != 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        polarity  = 1'b0;
        out_ready = 1'b0;
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        err_clr   = 1'b0;
`endif
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_mask", out_err_mask, 0);
        check("rst_out_error", out_error, 0);
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed decode cases; a word is at the head one cycle after accept.
        send(16'h5555, 1'b0);
        expect_head("tp_5555_p0", 8'hFF, 8'h00);
        out_ready = 1'b1;
        step(acc);
        out_ready = 1'b0;
        send(16'hAAAA, 1'b0);
        expect_head("tp_AAAA_p0", 8'h00, 8'h00);
        out_ready = 1'b1;
        step(acc);
        out_ready = 1'b0;
        send(16'h5555, 1'b1);
        expect_head("tp_5555_p1", 8'h00, 8'h00);
        out_ready = 1'b1;
        step(acc);
        out_ready = 1'b0;
        send(16'h5557, 1'b0);
        expect_head("tp_5557_p0", 8'hFE, 8'h01);
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        check("tp_errcnt_first", err_count, 1);
`endif
        out_ready = 1'b1;
        step(acc);
        step(acc);

        // Backpressure: fill to DEPTH, hold the fifth word, then drain.
        out_ready = 1'b0;
        send(16'h5555, 1'b0);
        send(16'hAAAA, 1'b0);
        send(16'h9999, 1'b0);
        send(16'h6666, 1'b0);
        #1;
        check("full_in_ready", in_ready, 0);
        in_data  = 16'h5A5A;
        in_valid = 1'b1;
        step(acc);
        step(acc);
        check("full_out_data_held", out_data, 8'hFF);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) step(acc);
        check("held_word_accepted", acc, 1);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step(acc);

        // Random continuous streaming with consumer stalls.
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            in_data   = rand_word();
            polarity  = $urandom_range(1) != 0;
            out_ready = $urandom_range(3) != 0;
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step(acc);
        check("drained", q.size(), 0);

`ifdef SERDESPHY_MDEC_ERRCNT_EN
        // Saturation at 3, then clear coinciding with an erroring accept.
        in_data  = 16'h5557;
        polarity = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) step(acc);
        in_valid = 1'b0;
        step(acc);
        check("errcnt_saturated", err_count, 3);
        in_valid = 1'b1;
        err_clr  = 1'b1;
        step(acc);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        step(acc);
        check("errcnt_clr_with_err", err_count, 1);
        err_clr = 1'b1;
        step(acc);
        err_clr = 1'b0;
        step(acc);
        check("errcnt_clr", err_count, 0);
        for (int k = 0; k < 6; k++) step(acc);
`endif

        // Reset in the middle of a burst discards everything at once.
        out_ready = 1'b0;
        send(16'h5555, 1'b0);
        send(16'h6666, 1'b0);
        send(16'h5557, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_mask", out_err_mask, 0);
`ifdef SERDESPHY_MDEC_ERRCNT_EN
        check("midrst_err_count", err_count, 0);
`endif
        q.delete();
        em = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(16'h9999, 1'b1);
        step(acc);
        step(acc);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
